// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver
//   Turns the red/green/blue/intensity registers from the UART colour
//   receiver into three intensity-scaled PWM outputs for an RGB LED. New
//   duties are taken into shadow registers only at period wraps. Because of
//   this, a UART update in the middle of a period cannot glitch the LED.
//
// Parameters
//   PRESCALE  clk cycles per PWM tick (1..65535)
//   INVERT    1 = active-low LED pins (common anode)
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-low reset
//   enable        1 = run PWM; 0 = counters held at 0, LEDs inactive
//   red/green/blue  8-bit colour levels
//   intensity     8-bit global brightness
//   led_r/g/b     PWM outputs
//   period_start  one-clk pulse when a new PWM period begins
module rgb_pwm_driver #(
    parameter int unsigned PRESCALE = 8,
    parameter bit          INVERT   = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    input  logic [7:0] intensity,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic       period_start
);

    localparam logic [15:0] PSC_LAST = 16'(PRESCALE - 1);
    localparam logic [7:0]  PCNT_LAST = 8'd254;
    localparam logic [2:0]  LED_IDLE = {3{INVERT}};

    logic [15:0]      psc;
    logic [7:0]       pcnt;
    logic             tick;
    logic             wrap;
    logic [8:0]       int_p1;
    logic [2:0][7:0]  level;
    logic [2:0][15:0] prod;
    logic [2:0][7:0]  scaled;
    logic [2:0][7:0]  shadow;
    logic [2:0]       led_q;

    // Channel index 0 = red, 1 = green, 2 = blue
    assign level  = {blue, green, red};
    assign int_p1 = {1'b0, intensity} + 9'd1;
    assign tick   = (psc == PSC_LAST) && enable;
    assign wrap   = tick && (pcnt == PCNT_LAST);

    // Max product is 255*256 = 0xFF00, so 16 bits hold it without loss
    always_comb begin
        prod = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            prod[i] = 16'(level[i]) * 16'(int_p1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scaled <= '0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                scaled[i] <= 8'(prod[i] >> 8);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psc  <= '0;
            pcnt <= '0;
        end else if (!enable) begin
            psc  <= '0;
            pcnt <= '0;
        end else begin
            psc <= (psc == PSC_LAST) ? '0 : psc + 16'd1;
            if (tick) begin
                pcnt <= (pcnt == PCNT_LAST) ? '0 : pcnt + 8'd1;
            end
        end
    end

    // While disabled the shadows track the scaled values every clk. Because
    // of this, the first period after enable rises already uses the full
    // duty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow <= '0;
        end else if (!enable || wrap) begin
            shadow <= scaled;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q        <= LED_IDLE;
            period_start <= 1'b0;
        end else begin
            period_start <= wrap;
            if (!enable) begin
                led_q <= LED_IDLE;
            end else begin
                for (int unsigned i = 0; i < 3; i++) begin
                    led_q[i] <= (pcnt < shadow[i]) ^ INVERT;
                end
            end
        end
    end

    assign led_r = led_q[0];
    assign led_g = led_q[1];
    assign led_b = led_q[2];

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb_rgb_pwm_driver
//   Directed bench for rgb_pwm_driver. Two instances share one set of
//   inputs: dut_a (PRESCALE=2, active-high) and dut_b (PRESCALE=1,
//   active-low). Outputs are sampled on the falling clock edge.
module tb_rgb_pwm_driver;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic [7:0] intensity;
    logic       lr_a, lg_a, lb_a, ps_a;
    logic       lr_b, lg_b, lb_b, ps_b;

    int passed = 0;
    int total  = 0;

    rgb_pwm_driver #(.PRESCALE(2), .INVERT(1'b0)) dut_a (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .intensity    (intensity),
        .led_r        (lr_a),
        .led_g        (lg_a),
        .led_b        (lb_a),
        .period_start (ps_a)
    );

    rgb_pwm_driver #(.PRESCALE(1), .INVERT(1'b1)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .intensity    (intensity),
        .led_r        (lr_b),
        .led_g        (lg_b),
        .led_b        (lb_b),
        .period_start (ps_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Returns at the falling edge where period_start of the chosen DUT is high
    task automatic wait_ps(input bit sel);
        int n;
        n = 0;
        @(negedge clk);
        while (!(sel ? ps_b : ps_a) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("ps_timeout", 0, 1);
    endtask

    // Counts high samples per LED over len falling edges. The last sample is
    // expected to coincide with the next period_start. Optionally changes
    // red at sample chg_at.
    task automatic count_period(input bit sel, input int len, input int chg_at,
                                input logic [7:0] chg_val,
                                output int hr, output int hg, output int hb,
                                output int ps_mid, output int ps_end);
        hr = 0; hg = 0; hb = 0; ps_mid = 0; ps_end = 0;
        for (int i = 1; i <= len; i++) begin
            @(negedge clk);
            if (i == chg_at) red = chg_val;
            hr += int'(sel ? lr_b : lr_a);
            hg += int'(sel ? lg_b : lg_a);
            hb += int'(sel ? lb_b : lb_a);
            if (i < len) ps_mid += int'(sel ? ps_b : ps_a);
            else         ps_end  = int'(sel ? ps_b : ps_a);
        end
    endtask

    initial begin
        int hr, hg, hb, pm, pe, n, any;
        reset = 1'b0; enable = 1'b1;
        red = 8'd255; green = 8'd0; blue = 8'd128; intensity = 8'd255;

        // Reset state
        @(negedge clk); #2;
        check("rst_leds_a", int'({lr_a, lg_a, lb_a}), 0);
        check("rst_leds_b", int'({lr_b, lg_b, lb_b}), 7);
        check("rst_ps", int'({ps_a, ps_b}), 0);
        @(negedge clk);
        reset = 1'b1;

        // 1: first period runs at duty 0, then 255/0/128 at PRESCALE=2
        any = 0;
        for (n = 1; n <= 2000; n++) begin
            @(negedge clk);
            if (ps_a) break;
            any |= int'(lr_a | lg_a | lb_a);
        end
        check("t1_dark_first_period", any, 0);
        check("t1_first_ps_at", n, 510);
        count_period(1'b0, 510, -1, 8'd0, hr, hg, hb, pm, pe);
        check("t1_red_high", hr, 510);
        check("t1_green_high", hg, 0);
        check("t1_blue_high", hb, 256);
        check("t1_ps_spacing", pe, 1);
        check("t1_ps_mid", pm, 0);

        // 2: red=128, intensity=127 -> 64, active-low, PRESCALE=1
        red = 8'd128; intensity = 8'd127;
        wait_ps(1'b1);
        count_period(1'b1, 255, -1, 8'd0, hr, hg, hb, pm, pe);
        count_period(1'b1, 255, -1, 8'd0, hr, hg, hb, pm, pe);
        check("t2_red_b_high", hr, 191);
        check("t2_ps_b_spacing", pe, 1);

        // 3: red 10 -> 200 mid-period, intensity 255 (scale is identity)
        red = 8'd10; intensity = 8'd255;
        wait_ps(1'b0);
        count_period(1'b0, 510, -1, 8'd0, hr, hg, hb, pm, pe);
        count_period(1'b0, 510, 100, 8'd200, hr, hg, hb, pm, pe);
        check("t3_old_duty_kept", hr, 20);
        count_period(1'b0, 510, -1, 8'd0, hr, hg, hb, pm, pe);
        check("t3_new_duty", hr, 400);

        // 6: intensity sweep with red=255 on active-low dut_b
        red = 8'd255;
        intensity = 8'd0;
        wait_ps(1'b1);
        count_period(1'b1, 255, -1, 8'd0, hr, hg, hb, pm, pe);
        count_period(1'b1, 255, -1, 8'd0, hr, hg, hb, pm, pe);
        check("t6_int0_inactive", hr, 255);
        intensity = 8'd1;
        count_period(1'b1, 255, -1, 8'd0, hr, hg, hb, pm, pe);
        count_period(1'b1, 255, -1, 8'd0, hr, hg, hb, pm, pe);
        check("t6_int1_one_tick", hr, 254);
        intensity = 8'd255;
        count_period(1'b1, 255, -1, 8'd0, hr, hg, hb, pm, pe);
        count_period(1'b1, 255, -1, 8'd0, hr, hg, hb, pm, pe);
        check("t6_int255_full", hr, 0);

        // 4: enable low for 5 clks mid-period
        wait_ps(1'b0);
        count_period(1'b0, 510, -1, 8'd0, hr, hg, hb, pm, pe);
        repeat (100) @(negedge clk);
        check("t4_red_before", int'(lr_a), 1);
        enable = 1'b0;
        @(negedge clk);
        check("t4_leds_a_off", int'({lr_a, lg_a, lb_a}), 0);
        check("t4_leds_b_off", int'({lr_b, lg_b, lb_b}), 7);
        repeat (4) @(negedge clk);
        check("t4_pcnt_held", int'(dut_a.pcnt), 0);
        enable = 1'b1;
        count_period(1'b0, 510, -1, 8'd0, hr, hg, hb, pm, pe);
        check("t4_red_full", hr, 510);
        check("t4_blue_full", hb, 256);
        check("t4_no_early_ps", pm, 0);
        check("t4_first_ps", pe, 1);

        // 5: asynchronous reset between edges while red is active
        repeat (50) @(negedge clk);
        check("t5_red_before", int'(lr_a), 1);
        #2 reset = 1'b0;
        #1;
        check("t5_leds_a_async", int'({lr_a, lg_a, lb_a}), 0);
        check("t5_leds_b_async", int'({lr_b, lg_b, lb_b}), 7);
        check("t5_pcnt_zero", int'(dut_a.pcnt), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        count_period(1'b0, 510, -1, 8'd0, hr, hg, hb, pm, pe);
        check("t5_dark_red", hr, 0);
        check("t5_dark_blue", hb, 0);
        check("t5_first_ps", pe, 1);
        count_period(1'b0, 510, -1, 8'd0, hr, hg, hb, pm, pe);
        check("t5_red_resumed", hr, 510);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
